// File: rtl/pwm_capture_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
//   Shared types and defaults for the PWM capture block.
//   cap_state_t     : measurement FSM states
//   CNT_W_DEF       : default counter / measurement width
//   SYNC_STAGES_DEF : default synchroniser depth
// -----------------------------------------------------------------------------
package pwm_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HIGH  = 2'd1,
      LOW   = 2'd2,
      STUCK = 2'd3
   } cap_state_t;

   localparam int CNT_W_DEF       = 16;
   localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/pwm_capture_if.sv
// -----------------------------------------------------------------------------
// pwm_capture_if
//   Bundles the PWM capture signals.
//   PwmIn     : asynchronous PWM waveform to measure
//   Enable    : 1 = measure, 0 = idle with outputs held
//   HighTime  : high cycles of the last complete period
//   Period    : rise-to-rise cycles of the last complete period
//   DutyValid : one-cycle pulse when HighTime/Period update
//   StuckHigh : input held high for the timeout, sticky until the next rise
//   StuckLow  : input held low for the timeout, sticky until the next rise
//   master drives PwmIn/Enable; slave (the capture block) drives the results.
// -----------------------------------------------------------------------------
interface pwm_capture_if #(
   parameter int CNT_W = pwm_pkg::CNT_W_DEF
) ();

   logic             PwmIn;
   logic             Enable;
   logic [CNT_W-1:0] HighTime;
   logic [CNT_W-1:0] Period;
   logic             DutyValid;
   logic             StuckHigh;
   logic             StuckLow;

   modport master (
      output PwmIn,
      output Enable,
      input  HighTime,
      input  Period,
      input  DutyValid,
      input  StuckHigh,
      input  StuckLow
   );

   modport slave (
      input  PwmIn,
      input  Enable,
      output HighTime,
      output Period,
      output DutyValid,
      output StuckHigh,
      output StuckLow
   );

endinterface

// File: rtl/pwm_capture_edge_sync.sv
// -----------------------------------------------------------------------------
// edge_sync
//   Synchronises an asynchronous level into MClk and produces registered
//   single-cycle rise/fall pulses.
//   MClk : clock
//   Rst  : asynchronous active-high reset, clears every flop
//   d    : asynchronous input
//   q    : synchronised level, aligned with the rise/fall pulses
//   rise : one-cycle pulse, SYNC edge-to-pulse latency STAGES+1 cycles
//   fall : one-cycle pulse, same latency as rise
//   STAGES must be at least 2.
// -----------------------------------------------------------------------------
module edge_sync #(
   parameter int STAGES = 2
) (
   input  logic MClk,
   input  logic Rst,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;
   logic              rise_q;
   logic              fall_q;

   // Synchroniser chain, previous-level flop and registered edge pulses.
   always_ff @(posedge MClk or posedge Rst) begin
      if (Rst) begin
         sync_q <= {STAGES{1'b0}};
         prev_q <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d};
         prev_q <= sync_q[STAGES-1];
         rise_q <= sync_q[STAGES-1] & ~prev_q;
         fall_q <= ~sync_q[STAGES-1] & prev_q;
      end
   end

   // prev_q is the level the pulses describe, so it is the one exported.
   assign q    = prev_q;
   assign rise = rise_q;
   assign fall = fall_q;

endmodule

// File: rtl/pwm_capture.sv
// -----------------------------------------------------------------------------
// pwm_capture
//   Measures an external PWM waveform: period (rise to rise) and high time in
//   MClk cycles, and flags an input stuck high or low for TIMEOUT cycles.
//   MClk : clock, all logic on posedge
//   Rst  : asynchronous active-high reset
//   cap  : pwm_capture_if.slave (PwmIn, Enable in; HighTime, Period,
//          DutyValid, StuckHigh, StuckLow out, all registered)
//   Parameters: CNT_W counter width, SYNC_STAGES synchroniser depth (>=2),
//   TIMEOUT cycles without a rise before stuck is declared (< 2**CNT_W).
// -----------------------------------------------------------------------------
module pwm_capture
   import pwm_pkg::*;
#(
   parameter int               CNT_W       = CNT_W_DEF,
   parameter int               SYNC_STAGES = SYNC_STAGES_DEF,
   parameter logic [CNT_W-1:0] TIMEOUT     = {CNT_W{1'b1}}
) (
   input logic        MClk,
   input logic        Rst,
   pwm_capture_if.slave cap
);

   localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] TIMEOUT_M1 = TIMEOUT - CNT_ONE;

   // Saturating increment: counters stop at TIMEOUT and never wrap.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      logic [CNT_W-1:0] r;
      if (v >= TIMEOUT) begin
         r = TIMEOUT;
      end else begin
         r = v + CNT_ONE;
      end
      return r;
   endfunction

   logic lvl_s;
   logic rise_s;
   logic fall_s;

   cap_state_t       state_q,      state_d;
   logic [CNT_W-1:0] per_cnt_q,    per_cnt_d;
   logic [CNT_W-1:0] hi_cnt_q,     hi_cnt_d;
   logic [CNT_W-1:0] high_time_q,  high_time_d;
   logic [CNT_W-1:0] period_q,     period_d;
   logic             duty_valid_q, duty_valid_d;
   logic             stuck_high_q, stuck_high_d;
   logic             stuck_low_q,  stuck_low_d;

   edge_sync #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .MClk (MClk),
      .Rst  (Rst),
      .d    (cap.PwmIn),
      .q    (lvl_s),
      .rise (rise_s),
      .fall (fall_s)
   );

   // Measurement FSM, counters and result next-state logic.
   always_comb begin
      state_d      = state_q;
      per_cnt_d    = per_cnt_q;
      hi_cnt_d     = hi_cnt_q;
      high_time_d  = high_time_q;
      period_d     = period_q;
      duty_valid_d = 1'b0;
      stuck_high_d = stuck_high_q;
      stuck_low_d  = stuck_low_q;

      if (!cap.Enable) begin
         // Disable beats any coincident edge; results and flags hold.
         state_d   = IDLE;
         per_cnt_d = CNT_ZERO;
         hi_cnt_d  = CNT_ZERO;
      end else begin
         case (state_q)
            IDLE: begin
               if (rise_s) begin
                  // First edge only gives a reference: nothing to report yet.
                  state_d      = HIGH;
                  per_cnt_d    = CNT_ONE;
                  hi_cnt_d     = CNT_ONE;
                  stuck_high_d = 1'b0;
                  stuck_low_d  = 1'b0;
               end else begin
                  per_cnt_d = CNT_ZERO;
                  hi_cnt_d  = CNT_ZERO;
               end
            end
            HIGH: begin
               if (per_cnt_q >= TIMEOUT_M1) begin
                  // Level in this cycle decides which way the input is stuck.
                  state_d      = STUCK;
                  per_cnt_d    = TIMEOUT;
                  stuck_high_d = lvl_s;
                  stuck_low_d  = ~lvl_s;
               end else if (fall_s) begin
                  // The fall cycle is already a low cycle: HiCnt freezes.
                  state_d   = LOW;
                  per_cnt_d = sat_inc(per_cnt_q);
               end else begin
                  per_cnt_d = sat_inc(per_cnt_q);
                  hi_cnt_d  = sat_inc(hi_cnt_q);
               end
            end
            LOW: begin
               if (rise_s) begin
                  // Rise wins over a coincident timeout; edge cycle opens the next period.
                  state_d      = HIGH;
                  high_time_d  = hi_cnt_q;
                  period_d     = per_cnt_q;
                  duty_valid_d = 1'b1;
                  per_cnt_d    = CNT_ONE;
                  hi_cnt_d     = CNT_ONE;
               end else if (per_cnt_q >= TIMEOUT_M1) begin
                  state_d      = STUCK;
                  per_cnt_d    = TIMEOUT;
                  stuck_high_d = lvl_s;
                  stuck_low_d  = ~lvl_s;
               end else begin
                  per_cnt_d = sat_inc(per_cnt_q);
               end
            end
            STUCK: begin
               if (rise_s) begin
                  state_d      = HIGH;
                  per_cnt_d    = CNT_ONE;
                  hi_cnt_d     = CNT_ONE;
                  stuck_high_d = 1'b0;
                  stuck_low_d  = 1'b0;
               end else begin
                  state_d = STUCK;
               end
            end
            default: begin
               state_d   = IDLE;
               per_cnt_d = CNT_ZERO;
               hi_cnt_d  = CNT_ZERO;
            end
         endcase
      end
   end

   // State, counter and output registers.
   always_ff @(posedge MClk or posedge Rst) begin
      if (Rst) begin
         state_q      <= IDLE;
         per_cnt_q    <= CNT_ZERO;
         hi_cnt_q     <= CNT_ZERO;
         high_time_q  <= CNT_ZERO;
         period_q     <= CNT_ZERO;
         duty_valid_q <= 1'b0;
         stuck_high_q <= 1'b0;
         stuck_low_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         per_cnt_q    <= per_cnt_d;
         hi_cnt_q     <= hi_cnt_d;
         high_time_q  <= high_time_d;
         period_q     <= period_d;
         duty_valid_q <= duty_valid_d;
         stuck_high_q <= stuck_high_d;
         stuck_low_q  <= stuck_low_d;
      end
   end

   assign cap.HighTime  = high_time_q;
   assign cap.Period    = period_q;
   assign cap.DutyValid = duty_valid_q;
   assign cap.StuckHigh = stuck_high_q;
   assign cap.StuckLow  = stuck_low_q;

endmodule
